// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (BOOT, RUN, WAIT)
//   fetch_entry_t : one queue entry, {pc, inst}
//   NOP_INST, DEFAULT_RESET_PC, INST_W : common constants
package fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Two-entry ordered FIFO holding fetched {pc, inst} pairs.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data at the tail
//   pop        : drop the head (ignored when empty)
//   flush      : synchronous clear, wins over push and pop
//   push_data  : entry to write
//   count      : number of valid entries (0..2)
//   head       : oldest entry (stale when count == 0)
module inst_fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    logic         pop_ok;

    assign pop_ok = pop && (count != 2'd0);
    assign head   = head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    // Count unchanged: the new entry lands wherever the
                    // remaining one ends up behind it.
                    if (count == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= push_data;
                        count  <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail_q <= push_data;
                        count  <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: keeps the PC, issues word reads on the
// instruction-memory port and buffers fetched words for the decoder.
//   clk, rst_n               : clock, async active-low reset
//   mem_addr_I/mem_ren_I     : fetch word address and request
//   mem_stall_I/mem_rdata_I  : memory busy, returned instruction word
//   redirect/redirect_pc     : flush pulse and new target PC
//   inst_valid/inst_ready    : decoder handshake
//   inst/inst_pc             : queue head instruction and its PC (0 when empty)
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:2]       mem_addr_I,
    output logic              mem_ren_I,
    input  logic              mem_stall_I,
    input  logic [INST_W-1:0] mem_rdata_I,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc
);

    localparam logic [1:0] QCNT_FULL = 2'(QDEPTH);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:2]  req_addr;
    logic         kill;

    logic [31:0]  target;
    logic         accept;
    logic         push;
    logic         pop;
    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t q_push_data;

    // Low two bits of the target are dropped by masking.
    assign target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        case (state)
            BOOT:    mem_ren_I = 1'b0;
            RUN:     mem_ren_I = (q_count < QCNT_FULL) && !redirect;
            default: mem_ren_I = 1'b1;
        endcase
    end

    // While stalled the request address is frozen even if pc was redirected.
    assign mem_addr_I = (state == WAIT) ? req_addr : pc[31:2];

    assign accept = mem_ren_I && !mem_stall_I;
    // A WAIT accept is dropped if the request was killed earlier or in this cycle.
    assign push   = accept && ((state == RUN) || ((state == WAIT) && !kill && !redirect));
    assign pop    = inst_valid && inst_ready;

    assign q_push_data.pc   = pc;
    assign q_push_data.inst = mem_rdata_I;

    inst_fetch_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (q_push_data),
        .count     (q_count),
        .head      (q_head)
    );

    assign inst_valid = (q_count != 2'd0);
    assign inst       = inst_valid ? q_head.inst : '0;
    assign inst_pc    = inst_valid ? q_head.pc   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_addr <= RESET_PC[31:2];
            kill     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    if (redirect) pc <= target;
                end
                RUN: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (accept) begin
                        pc <= pc + 32'd4;
                    end else if (mem_ren_I) begin
                        state    <= WAIT;
                        req_addr <= pc[31:2];
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (accept && !kill) begin
                        pc <= pc + 32'd4;
                    end
                    if (accept) begin
                        state <= RUN;
                        kill  <= 1'b0;
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by
// randomized stimulus, all checked against a queue-based reference model.
module tb_inst_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:2] mem_addr_I;
    logic        mem_ren_I;
    logic        mem_stall_I = 1'b0;
    logic [31:0] mem_rdata_I = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC (TB_RESET_PC),
        .QDEPTH   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr_I  (mem_addr_I),
        .mem_ren_I   (mem_ren_I),
        .mem_stall_I (mem_stall_I),
        .mem_rdata_I (mem_rdata_I),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: known words at the first three addresses.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'd0:   return 32'h0000_0013;
            30'd1:   return 32'h0050_0093;
            30'd2:   return 32'h00A0_0113;
            default: return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
        endcase
    endfunction

    // Reference model: FIFO of fetched words plus the fetch bookkeeping.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    bit          m_boot;
    bit          m_wait;
    bit          m_kill;
    logic [31:0] m_pc;
    logic [29:0] m_held;

    task automatic model_reset();
        mq.delete();
        m_boot = 1'b1;
        m_wait = 1'b0;
        m_kill = 1'b0;
        m_pc   = TB_RESET_PC;
        m_held = '0;
    endtask

    // One cycle: check registered outputs, drive inputs, check the request,
    // advance the model, wait for the next falling edge.
    task automatic step(input bit stall, input bit ready, input bit redir, input logic [31:0] rpc);
        logic [29:0] exp_addr;
        logic [31:0] tgt;
        bit          exp_ren;
        bit          acc;
        bit          pop;

        exp_addr = m_wait ? m_held : m_pc[31:2];
        check32("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
        check32("inst",       inst,    (mq.size() != 0) ? mq[0].word : 32'h0);
        check32("inst_pc",    inst_pc, (mq.size() != 0) ? mq[0].pc   : 32'h0);
        check32("mem_addr",   {2'b00, mem_addr_I}, {2'b00, exp_addr});

        mem_stall_I = stall;
        inst_ready  = ready;
        redirect    = redir;
        redirect_pc = rpc;
        mem_rdata_I = mem_word(exp_addr);
        #1;
        exp_ren = m_boot ? 1'b0 : (m_wait ? 1'b1 : ((mq.size() < 2) && !redir));
        check32("mem_ren", {31'b0, mem_ren_I}, {31'b0, exp_ren});

        acc = exp_ren && !stall;
        pop = (mq.size() != 0) && ready;
        tgt = {rpc[31:2], 2'b00};

        if (m_boot) begin
            m_boot = 1'b0;
            if (redir) begin
                mq.delete();
                m_pc = tgt;
            end
        end else begin
            if (redir) mq.delete();
            else if (pop) void'(mq.pop_front());
            if (acc && !redir && !(m_wait && m_kill)) begin
                mq.push_back(ent_t'{m_pc, mem_word(exp_addr)});
                m_pc = m_pc + 32'd4;
            end
            if (redir) m_pc = tgt;
            if (m_wait) begin
                if (acc) begin
                    m_wait = 1'b0;
                    m_kill = 1'b0;
                end else if (redir) begin
                    m_kill = 1'b1;
                end
            end else if (exp_ren && stall) begin
                m_wait = 1'b1;
                m_held = m_pc[31:2];
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        mem_stall_I = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1;
        check32("rst_ren",   {31'b0, mem_ren_I},  32'h0);
        check32("rst_addr",  {2'b00, mem_addr_I}, {2'b00, TB_RESET_PC[31:2]});
        check32("rst_valid", {31'b0, inst_valid}, 32'h0);
        check32("rst_inst",  inst,    32'h0);
        check32("rst_pc",    inst_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, rpc);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // boot then streaming
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);
        // backpressure, then drain
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
        // three-cycle stall
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, '0);
        // redirect while stalled
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0180);
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
        // redirect coinciding with the accept that ends a stall
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
        // misaligned target at the top of memory, fetch wraps to 0
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

        random_steps(4000);

        // reset in the middle of traffic, possibly mid-stall
        step(1'b1, 1'b0, 1'b0, '0);
        do_reset();
        random_steps(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
